// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the load/store unit: funct3 codes, FSM encoding,
// byte-enable constants, the registered-op record and the legality check.
package load_store_unit_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  localparam logic [3:0] BE_BYTE = 4'b0001;
  localparam logic [3:0] BE_HALF = 4'b0011;
  localparam logic [3:0] BE_WORD = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_WB    = 2'd2,
    ST_FAULT = 2'd3
  } lsu_state_e;

  typedef struct packed {
    logic        we;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] data;
    logic [4:0]  rd;
  } lsu_op_t;

  // funct3[1:0] is the access size; funct3[2] (unsigned) is only legal on sub-word loads.
  function automatic logic op_illegal(input logic we, input logic [2:0] f3, input logic [1:0] a);
    case (f3[1:0])
      2'b00:   op_illegal = we & f3[2];
      2'b01:   op_illegal = (we & f3[2]) | a[0];
      2'b10:   op_illegal = f3[2] | (a != 2'b00);
      default: op_illegal = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/load_store_unit_load_align.sv
// Load data extraction: picks the byte/half out of the read word by address
// and sign- or zero-extends it according to funct3.
module lsu_load_align
  import load_store_unit_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr,
  input  logic [2:0]  funct3,
  output logic [31:0] result
);

  logic [31:0] shifted;
  logic [7:0]  b;
  logic [15:0] h;
  logic        sext;

  always_comb begin
    shifted = rdata >> {addr, 3'b000};
    b       = shifted[7:0];
    h       = addr[1] ? rdata[31:16] : rdata[15:0];
    sext    = ~funct3[2];
    result  = rdata;
    case (funct3[1:0])
      2'b00:   result = {{24{b[7] & sext}}, b};
      2'b01:   result = {{16{h[15] & sext}}, h};
      default: result = rdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Memory-stage load/store unit: accepts one op from execute, checks alignment,
// runs a req/ack transaction with timeout, and returns extended load data.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter logic [7:0] TIMEOUT = 8'd64
) (
  input  logic        ip_clk,
  input  logic        ip_rst_n,
  input  logic        ip_valid,
  input  logic        ip_mem_write,
  input  logic [2:0]  ip_funct3,
  input  logic [31:0] ip_addr,
  input  logic [31:0] ip_store_data,
  input  logic [4:0]  ip_rd,
  input  logic        ip_mem_ack,
  input  logic        ip_mem_err,
  input  logic [31:0] ip_mem_rdata,
  output logic        op_mem_req,
  output logic        op_mem_we,
  output logic [31:0] op_mem_addr,
  output logic [31:0] op_mem_wdata,
  output logic [3:0]  op_mem_be,
  output logic        op_stall,
  output logic        op_done,
  output logic        op_wb_valid,
  output logic [4:0]  op_wb_rd,
  output logic [31:0] op_wb_data,
  output logic        op_misaligned,
  output logic        op_access_fault,
  output logic [31:0] op_fault_addr
);

  lsu_state_e  state, state_nxt;
  lsu_op_t     op;
  logic [7:0]  cnt;
  logic        fault_mis;
  logic        accept, illegal;
  logic [3:0]  be;
  logic [31:0] wdata, ld_data;

  assign accept  = (state == ST_IDLE) & ip_valid;
  assign illegal = op_illegal(ip_mem_write, ip_funct3, ip_addr[1:0]);

  lsu_load_align u_align (
    .rdata  (ip_mem_rdata),
    .addr   (op.addr[1:0]),
    .funct3 (op.funct3),
    .result (ld_data)
  );

  // Store lane steering from the registered op; loads read the whole word.
  always_comb begin
    be    = BE_WORD;
    wdata = '0;
    if (op.we) begin
      case (op.funct3[1:0])
        2'b00: begin
          be    = BE_BYTE << op.addr[1:0];
          wdata = {4{op.data[7:0]}};
        end
        2'b01: begin
          be    = op.addr[1] ? {BE_HALF[1:0], 2'b00} : BE_HALF;
          wdata = {2{op.data[15:0]}};
        end
        default: begin
          be    = BE_WORD;
          wdata = op.data;
        end
      endcase
    end
  end

  always_comb begin
    state_nxt       = state;
    op_mem_req      = 1'b0;
    op_mem_we       = 1'b0;
    op_mem_addr     = '0;
    op_mem_wdata    = '0;
    op_mem_be       = '0;
    op_done         = 1'b0;
    op_wb_valid     = 1'b0;
    op_misaligned   = 1'b0;
    op_access_fault = 1'b0;
    case (state)
      ST_IDLE: if (ip_valid) state_nxt = illegal ? ST_FAULT : ST_REQ;
      ST_REQ: begin
        op_mem_req   = 1'b1;
        op_mem_we    = op.we;
        op_mem_addr  = {op.addr[31:2], 2'b00};
        op_mem_wdata = wdata;
        op_mem_be    = be;
        // ack beats a coincident timeout; err beats data
        if (ip_mem_ack)                  state_nxt = ip_mem_err ? ST_FAULT : ST_WB;
        else if (cnt == TIMEOUT - 8'd1)  state_nxt = ST_FAULT;
      end
      ST_WB: begin
        op_done     = 1'b1;
        op_wb_valid = ~op.we & (op.rd != 5'd0);
        state_nxt   = ST_IDLE;
      end
      default: begin
        op_misaligned   = fault_mis;
        op_access_fault = ~fault_mis;
        state_nxt       = ST_IDLE;
      end
    endcase
  end

  // Gated by reset so stall is low while the unit is held in reset.
  assign op_stall = ip_rst_n & (accept | (state == ST_REQ));

  always_ff @(posedge ip_clk or negedge ip_rst_n) begin
    if (!ip_rst_n) begin
      state         <= ST_IDLE;
      op            <= '0;
      cnt           <= '0;
      fault_mis     <= 1'b0;
      op_wb_rd      <= '0;
      op_wb_data    <= '0;
      op_fault_addr <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        op        <= '{we: ip_mem_write, funct3: ip_funct3, addr: ip_addr,
                       data: ip_store_data, rd: ip_rd};
        cnt       <= '0;
        fault_mis <= illegal;
      end
      if (state == ST_REQ) cnt <= cnt + 8'd1;
      if (state_nxt == ST_WB) begin
        op_wb_rd   <= op.rd;
        op_wb_data <= ld_data;
      end
      if (state_nxt == ST_FAULT)
        op_fault_addr <= (state == ST_IDLE) ? ip_addr : op.addr;
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: table of single transactions plus
// hand-written reset sequences.
module tb_load_store_unit;

  logic        ip_clk = 1'b0;
  logic        ip_rst_n = 1'b0;
  logic        ip_valid = 1'b0, ip_mem_write = 1'b0;
  logic [2:0]  ip_funct3 = '0;
  logic [31:0] ip_addr = '0, ip_store_data = '0, ip_mem_rdata = '0;
  logic [4:0]  ip_rd = '0;
  logic        ip_mem_ack = 1'b0, ip_mem_err = 1'b0;
  logic        op_mem_req, op_mem_we, op_stall, op_done, op_wb_valid;
  logic        op_misaligned, op_access_fault;
  logic [31:0] op_mem_addr, op_mem_wdata, op_wb_data, op_fault_addr;
  logic [3:0]  op_mem_be;
  logic [4:0]  op_wb_rd;

  int total = 0;
  int bad = 0;

  always #5 ip_clk = ~ip_clk;

  load_store_unit #(.TIMEOUT(8'd8)) dut (
    .ip_clk(ip_clk), .ip_rst_n(ip_rst_n), .ip_valid(ip_valid),
    .ip_mem_write(ip_mem_write), .ip_funct3(ip_funct3), .ip_addr(ip_addr),
    .ip_store_data(ip_store_data), .ip_rd(ip_rd), .ip_mem_ack(ip_mem_ack),
    .ip_mem_err(ip_mem_err), .ip_mem_rdata(ip_mem_rdata),
    .op_mem_req(op_mem_req), .op_mem_we(op_mem_we), .op_mem_addr(op_mem_addr),
    .op_mem_wdata(op_mem_wdata), .op_mem_be(op_mem_be), .op_stall(op_stall),
    .op_done(op_done), .op_wb_valid(op_wb_valid), .op_wb_rd(op_wb_rd),
    .op_wb_data(op_wb_data), .op_misaligned(op_misaligned),
    .op_access_fault(op_access_fault), .op_fault_addr(op_fault_addr)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr, sdata;
    logic [4:0]  rd;
    int          dly;      // REQ cycles without ack before ack; 255 = never
    logic        err;
    logic [31:0] rdata;
    int          exp_req;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata;
    logic        exp_done, exp_wbv;
    logic [31:0] exp_wbd;
    logic        exp_mis, exp_af;
  } vec_t;

  function automatic vec_t mk(logic we, logic [2:0] f3, logic [31:0] addr, logic [31:0] sdata,
                              logic [4:0] rd, int dly, logic err, logic [31:0] rdata,
                              int exp_req, logic [3:0] exp_be, logic [31:0] exp_wdata,
                              logic exp_done, logic exp_wbv, logic [31:0] exp_wbd,
                              logic exp_mis, logic exp_af);
    vec_t v;
    v.we = we; v.f3 = f3; v.addr = addr; v.sdata = sdata; v.rd = rd; v.dly = dly;
    v.err = err; v.rdata = rdata; v.exp_req = exp_req; v.exp_be = exp_be;
    v.exp_wdata = exp_wdata; v.exp_done = exp_done; v.exp_wbv = exp_wbv;
    v.exp_wbd = exp_wbd; v.exp_mis = exp_mis; v.exp_af = exp_af;
    return v;
  endfunction

  task automatic run(input vec_t v, input int idx);
    int req_cnt = 0, stall_cnt = 0;
    logic fin = 1'b0, got_we = 1'b0, got_done = 1'b0, got_wbv = 1'b0;
    logic got_mis = 1'b0, got_af = 1'b0;
    logic [31:0] got_addr = '0, got_wdata = '0, got_wbd = '0, got_fa = '0;
    logic [3:0] got_be = '0;
    logic [4:0] got_rd = '0;
    string tag = $sformatf("v%0d", idx);
    @(negedge ip_clk);
    ip_valid = 1'b1; ip_mem_write = v.we; ip_funct3 = v.f3; ip_addr = v.addr;
    ip_store_data = v.sdata; ip_rd = v.rd;
    for (int cyc = 0; cyc < 40 && !fin; cyc++) begin
      if (cyc > 0) begin
        @(negedge ip_clk);
        ip_valid = 1'b0; ip_mem_ack = 1'b0; ip_mem_err = 1'b0;
      end
      #1;
      if (op_stall) stall_cnt++;
      if (op_mem_req) begin
        if (req_cnt == 0) begin
          got_addr = op_mem_addr; got_be = op_mem_be; got_wdata = op_mem_wdata; got_we = op_mem_we;
        end
        if (req_cnt == v.dly) begin
          ip_mem_ack = 1'b1; ip_mem_err = v.err; ip_mem_rdata = v.rdata;
        end
        req_cnt++;
      end
      if (op_done || op_misaligned || op_access_fault) begin
        fin = 1'b1;
        got_done = op_done; got_wbv = op_wb_valid; got_wbd = op_wb_data; got_rd = op_wb_rd;
        got_mis = op_misaligned; got_af = op_access_fault; got_fa = op_fault_addr;
      end
    end
    check({tag, " finished"}, fin, 1);
    check({tag, " req_cycles"}, req_cnt, v.exp_req);
    check({tag, " stall_cycles"}, stall_cnt, v.exp_req + 1);
    if (v.exp_req > 0) begin
      check({tag, " mem_addr"}, got_addr, {v.addr[31:2], 2'b00});
      check({tag, " mem_be"}, got_be, v.exp_be);
      check({tag, " mem_we"}, got_we, v.we);
      if (v.we) check({tag, " mem_wdata"}, got_wdata, v.exp_wdata);
    end
    check({tag, " done"}, got_done, v.exp_done);
    check({tag, " wb_valid"}, got_wbv, v.exp_wbv);
    if (v.exp_wbv) begin
      check({tag, " wb_data"}, got_wbd, v.exp_wbd);
      check({tag, " wb_rd"}, got_rd, v.rd);
    end
    check({tag, " misaligned"}, got_mis, v.exp_mis);
    check({tag, " access_fault"}, got_af, v.exp_af);
    if (v.exp_mis || v.exp_af) check({tag, " fault_addr"}, got_fa, v.addr);
    @(negedge ip_clk);
    ip_mem_ack = 1'b0; ip_mem_err = 1'b0;
    #1;
    check({tag, " back_to_idle"},
          {op_done, op_wb_valid, op_misaligned, op_access_fault, op_mem_req, op_stall}, 0);
  endtask

  vec_t vecs[17];

  initial begin
    vecs[0]  = mk(0, 3'b010, 32'h0000_1004, 0, 5'd5, 2, 0, 32'hDEAD_BEEF, 3, 4'hF, 0, 1, 1, 32'hDEAD_BEEF, 0, 0);
    vecs[1]  = mk(0, 3'b000, 32'h0000_1003, 0, 5'd6, 0, 0, 32'h80FF_FF7F, 1, 4'hF, 0, 1, 1, 32'hFFFF_FF80, 0, 0);
    vecs[2]  = mk(0, 3'b100, 32'h0000_1003, 0, 5'd6, 0, 0, 32'h80FF_FF7F, 1, 4'hF, 0, 1, 1, 32'h0000_0080, 0, 0);
    vecs[3]  = mk(0, 3'b001, 32'h0000_1002, 0, 5'd7, 0, 0, 32'h80FF_FF7F, 1, 4'hF, 0, 1, 1, 32'hFFFF_80FF, 0, 0);
    vecs[4]  = mk(0, 3'b101, 32'h0000_1000, 0, 5'd7, 0, 0, 32'h80FF_FF7F, 1, 4'hF, 0, 1, 1, 32'h0000_FF7F, 0, 0);
    vecs[5]  = mk(0, 3'b000, 32'h0000_1000, 0, 5'd8, 1, 0, 32'h80FF_FF7F, 2, 4'hF, 0, 1, 1, 32'h0000_007F, 0, 0);
    vecs[6]  = mk(1, 3'b000, 32'h0000_2002, 32'h1234_56AB, 5'd7, 1, 0, 0, 2, 4'b0100, 32'hABAB_ABAB, 1, 0, 0, 0, 0);
    vecs[7]  = mk(1, 3'b001, 32'h0000_2002, 32'hCAFE_1234, 5'd7, 0, 0, 0, 1, 4'b1100, 32'h1234_1234, 1, 0, 0, 0, 0);
    vecs[8]  = mk(1, 3'b010, 32'h0000_2004, 32'h89AB_CDEF, 5'd7, 0, 0, 0, 1, 4'b1111, 32'h89AB_CDEF, 1, 0, 0, 0, 0);
    vecs[9]  = mk(1, 3'b001, 32'h0000_2001, 32'h5555_5555, 5'd1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    vecs[10] = mk(0, 3'b010, 32'h0000_3002, 0, 5'd1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    vecs[11] = mk(0, 3'b011, 32'h0000_3000, 0, 5'd1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    vecs[12] = mk(1, 3'b100, 32'h0000_3004, 0, 5'd1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    vecs[13] = mk(0, 3'b010, 32'h0000_4000, 0, 5'd3, 0, 1, 32'hFFFF_FFFF, 1, 4'hF, 0, 0, 0, 0, 0, 1);
    vecs[14] = mk(0, 3'b010, 32'h0000_5000, 0, 5'd3, 255, 0, 0, 8, 4'hF, 0, 0, 0, 0, 0, 1);
    vecs[15] = mk(0, 3'b010, 32'h0000_1008, 0, 5'd0, 0, 0, 32'h1111_1111, 1, 4'hF, 0, 1, 0, 0, 0, 0);
    vecs[16] = mk(0, 3'b010, 32'h0000_600C, 0, 5'd9, 7, 0, 32'h1357_9BDF, 8, 4'hF, 0, 1, 1, 32'h1357_9BDF, 0, 0);

    // held in reset with a valid op offered: everything stays low
    ip_valid = 1'b1;
    #12;
    check("reset_outputs",
          {op_mem_req, op_mem_we, op_stall, op_done, op_wb_valid, op_misaligned,
           op_access_fault, op_mem_be}, 0);
    check("reset_regs", op_wb_data | op_fault_addr | op_mem_addr | op_mem_wdata | {27'd0, op_wb_rd}, 0);
    ip_valid = 1'b0;
    @(negedge ip_clk);
    ip_rst_n = 1'b1;

    for (int i = 0; i < 17; i++) run(vecs[i], i);

    // reset dropped mid-REQ: req and stall fall without waiting for an edge
    @(negedge ip_clk);
    ip_valid = 1'b1; ip_mem_write = 1'b0; ip_funct3 = 3'b010; ip_addr = 32'h0000_7000; ip_rd = 5'd4;
    @(negedge ip_clk);
    ip_valid = 1'b0;
    #1;
    check("mid_req_active", {op_mem_req, op_stall}, 2'b11);
    #2;
    ip_rst_n = 1'b0;
    #1;
    check("async_reset_req_stall", {op_mem_req, op_stall}, 0);
    @(negedge ip_clk);
    ip_rst_n = 1'b1;
    @(negedge ip_clk);
    #1;
    check("after_reset_idle", {op_mem_req, op_stall, op_done, op_access_fault}, 0);

    // a fresh op still works after the abandoned one
    run(vecs[0], 99);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
